// File: rtl/stage_mem_pkg.sv
// ---------------------------------------------------------------------------
// stage_mem_pkg
//   Shared types for the memory-access stage: the memop bundle produced by
//   decode, the register-file address enum, the MEM stage FSM states,
//   byte-lane write-enable patterns and the byte-swap / alignment helpers.
//   No ports (package).
// ---------------------------------------------------------------------------
package stage_mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } ls_type_enum;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } ls_width_enum;

  typedef struct packed {
    ls_type_enum  ls_type;
    ls_width_enum ls_width;
    logic         sign;      // 1 = sign-extend narrow loads
  } memop_struct;

  typedef enum logic [4:0] {
    REG_ZERO, REG_AT, REG_V0, REG_V1, REG_A0, REG_A1, REG_A2, REG_A3,
    REG_T0, REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
    REG_S0, REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
    REG_T8, REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
  } reg_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_enum;

  // Write-enable patterns for lane 0; shifted left by the byte offset.
  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

  // Converts between MIPS big-endian byte order and little-endian lanes.
  function automatic word_t byteswap(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic misaligned(input ls_width_enum width,
                                      input logic [1:0]   off);
    logic bad;
    bad = 1'b0;
    case (width)
      LS_HALF: bad = off[0];
      LS_WORD: bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/stage_mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational lane steering between MIPS big-endian register data
//   and the little-endian data-memory word.
//   Store side: replicates/swaps register data into lanes and builds the
//   byte write enables. Load side: picks the addressed lanes from the raw
//   read word and sign/zero-extends them.
//   Low address bits that do not apply to the access width are ignored
//   (half uses off[1] only, word uses lane 0).
// Ports:
//   width     in  access width (byte/half/word)
//   sign      in  sign-extend narrow loads
//   off       in  byte offset, addr[1:0]
//   st_data   in  store data (rt), big-endian register value
//   ld_raw    in  raw little-endian read word
//   st_wdata  out lane-aligned store word
//   st_we     out byte-lane write enables
//   ld_data   out extracted, extended load value
// ---------------------------------------------------------------------------
module mem_lane_align
  import stage_mem_pkg::*;
(
  input  ls_width_enum width,
  input  logic         sign,
  input  logic [1:0]   off,
  input  word_t        st_data,
  input  word_t        ld_raw,
  output word_t        st_wdata,
  output logic [3:0]   st_we,
  output word_t        ld_data
);

  logic [1:0]  eff_off;
  logic [1:0]  eff_off_hi;
  logic [7:0]  lane [4];
  logic [15:0] half_val;
  logic [7:0]  byte_val;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = ld_raw[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    eff_off = off;
    case (width)
      LS_HALF: eff_off = {off[1], 1'b0};
      LS_BYTE: eff_off = off;
      default: eff_off = 2'b00;
    endcase
  end

  // Second lane of a half access; eff_off is even for halves.
  assign eff_off_hi = {eff_off[1], 1'b1};
  assign byte_val   = lane[eff_off];
  // MIPS byte 0 is most significant, so the lower lane is the high byte.
  assign half_val   = {lane[eff_off], lane[eff_off_hi]};

  always_comb begin
    st_wdata = byteswap(st_data);
    st_we    = WE_WORD;
    ld_data  = byteswap(ld_raw);
    case (width)
      LS_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_we    = WE_BYTE << eff_off;
        ld_data  = {{24{sign & byte_val[7]}}, byte_val};
      end
      LS_HALF: begin
        st_wdata = {2{st_data[7:0], st_data[15:8]}};
        st_we    = WE_HALF << eff_off;
        ld_data  = {{16{sign & half_val[15]}}, half_val};
      end
      default: begin
        st_wdata = byteswap(st_data);
        st_we    = WE_WORD;
        ld_data  = byteswap(ld_raw);
      end
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// ---------------------------------------------------------------------------
// stage_mem
//   MIPS memory-access stage. Non-memory instructions pass straight through
//   to write-back in the same cycle. Loads and stores run a req/ack
//   transaction on the data-memory port (IDLE -> REQ -> DONE) while holding
//   the pipe with mem_o_stall; the MEM input bundle therefore stays stable
//   for the whole transaction and is used directly by the lane aligner.
//   A request outstanding for TIMEOUT cycles without dm_ack is abandoned
//   and reported through mem_o_buserr (TIMEOUT=0 disables this).
//   Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip
//   the bus entirely and finish with mem_o_buserr set.
// Parameters:
//   TIMEOUT  REQ cycles without ack before bus error (0 = never)
//   CNT_W    timeout counter width, 2**CNT_W > TIMEOUT
// Ports:
//   cpu_clk_50M   in  clock
//   cpu_rst_n     in  synchronous active-low reset
//   mem_i_valid   in  instruction valid in MEM
//   mem_i_memop   in  load/store type, width, sign
//   mem_i_dm2rf   in  load result goes to RF
//   mem_i_rfwe    in  RF write enable
//   mem_i_rfwa    in  RF write address
//   mem_i_aluout  in  ALU result / effective address
//   mem_i_dmdin   in  store data
//   mem_o_stall   out freeze IF..MEM
//   dm_req        out memory request
//   dm_we         out byte-lane write enables (0 = read)
//   dm_addr       out word address
//   dm_wdata      out little-endian lane data
//   dm_ack        in  transaction complete
//   dm_rdata      in  raw read word, valid with dm_ack
//   mem_o_valid   out result valid to WB
//   mem_o_rfwe    out RF write enable
//   mem_o_rfwa    out RF write address
//   mem_o_wd      out RF write data
//   mem_o_buserr  out bus error on this instruction
// ---------------------------------------------------------------------------
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        mem_i_valid,
  input  memop_struct mem_i_memop,
  input  logic        mem_i_dm2rf,
  input  logic        mem_i_rfwe,
  input  reg_enum     mem_i_rfwa,
  input  word_t       mem_i_aluout,
  input  word_t       mem_i_dmdin,
  output logic        mem_o_stall,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output word_t       dm_addr,
  output word_t       dm_wdata,
  input  logic        dm_ack,
  input  word_t       dm_rdata,
  output logic        mem_o_valid,
  output logic        mem_o_rfwe,
  output reg_enum     mem_o_rfwa,
  output word_t       mem_o_wd,
  output logic        mem_o_buserr
);

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mem_state_enum    state_reg, state_next;
  logic             req_reg, req_next;
  logic [3:0]       we_reg, we_next;
  word_t            addr_reg, addr_next;
  word_t            wdata_reg, wdata_next;
  word_t            ld_reg, ld_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  logic             is_mem;
  word_t            st_wdata;
  logic [3:0]       st_we;
  word_t            ld_data;

  assign is_mem = mem_i_valid && (mem_i_memop.ls_type != MEM_NONE);

  mem_lane_align u_align (
    .width    (mem_i_memop.ls_width),
    .sign     (mem_i_memop.sign),
    .off      (mem_i_aluout[1:0]),
    .st_data  (mem_i_dmdin),
    .ld_raw   (dm_rdata),
    .st_wdata (st_wdata),
    .st_we    (st_we),
    .ld_data  (ld_data)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      we_reg    <= WE_NONE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ld_reg    <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      ld_reg    <= ld_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    ld_next    = ld_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (is_mem) begin
          cnt_next = '0;
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned(mem_i_memop.ls_width, mem_i_aluout[1:0])) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else
`endif
          begin
            req_next   = 1'b1;
            addr_next  = {mem_i_aluout[31:2], 2'b00};
            we_next    = (mem_i_memop.ls_type == MEM_STORE) ? st_we : WE_NONE;
            wdata_next = (mem_i_memop.ls_type == MEM_STORE) ? st_wdata : '0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (dm_ack) begin
          ld_next    = ld_data;
          req_next   = 1'b0;
          state_next = DONE;
        end else if (TO_EN && (cnt_reg == TO_LAST)) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        err_next   = 1'b0;
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage outputs. IDLE serves non-memory ops combinationally; a memory op
  // seen in IDLE only stalls until its result is presented in DONE.
  always_comb begin
    mem_o_stall = 1'b0;
    mem_o_valid = 1'b0;
    mem_o_rfwe  = 1'b0;
    mem_o_wd    = mem_i_aluout;
    case (state_reg)
      IDLE: begin
        mem_o_stall = is_mem;
        mem_o_valid = mem_i_valid && !is_mem;
        mem_o_rfwe  = mem_i_rfwe && mem_i_valid && !is_mem;
      end
      REQ: mem_o_stall = 1'b1;
      DONE: begin
        mem_o_valid = 1'b1;
        mem_o_rfwe  = mem_i_rfwe && mem_i_dm2rf && !err_reg;
        mem_o_wd    = ld_reg;
      end
      default: mem_o_stall = 1'b0;
    endcase
    if (!cpu_rst_n) begin
      mem_o_stall = 1'b0;
      mem_o_valid = 1'b0;
      mem_o_rfwe  = 1'b0;
    end
  end

  assign mem_o_rfwa   = mem_i_rfwa;
  assign mem_o_buserr = err_reg;
  assign dm_req       = req_reg;
  assign dm_we        = we_reg;
  assign dm_addr      = addr_reg;
  assign dm_wdata     = wdata_reg;

endmodule

// File: tb/tb_stage_mem.sv
`timescale 1ns/1ps
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  logic        mem_i_valid = 1'b0;
  memop_struct mem_i_memop = '{ls_type: MEM_NONE, ls_width: LS_WORD, sign: 1'b0};
  logic        mem_i_dm2rf = 1'b0;
  logic        mem_i_rfwe  = 1'b0;
  reg_enum     mem_i_rfwa  = REG_ZERO;
  word_t       mem_i_aluout = '0;
  word_t       mem_i_dmdin  = '0;
  logic        mem_o_stall;
  logic        dm_req;
  logic [3:0]  dm_we;
  word_t       dm_addr;
  word_t       dm_wdata;
  logic        dm_ack   = 1'b0;
  word_t       dm_rdata = '0;
  logic        mem_o_valid;
  logic        mem_o_rfwe;
  reg_enum     mem_o_rfwa;
  word_t       mem_o_wd;
  logic        mem_o_buserr;

  stage_mem #(.TIMEOUT(4), .CNT_W(5)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .mem_i_valid  (mem_i_valid),
    .mem_i_memop  (mem_i_memop),
    .mem_i_dm2rf  (mem_i_dm2rf),
    .mem_i_rfwe   (mem_i_rfwe),
    .mem_i_rfwa   (mem_i_rfwa),
    .mem_i_aluout (mem_i_aluout),
    .mem_i_dmdin  (mem_i_dmdin),
    .mem_o_stall  (mem_o_stall),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .mem_o_valid  (mem_o_valid),
    .mem_o_rfwe   (mem_o_rfwe),
    .mem_o_rfwa   (mem_o_rfwa),
    .mem_o_wd     (mem_o_wd),
    .mem_o_buserr (mem_o_buserr)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  typedef struct {
    word_t   wd;
    logic    chk_wd;
    logic    rfwe;
    reg_enum rfwa;
    logic    buserr;
    int      stalls;
  } res_t;

  typedef struct {
    word_t      addr;
    logic [3:0] we;
    word_t      wdata;
    word_t      wmask;
    int         len;
  } bus_t;

  res_t  res_q[$];
  bus_t  bus_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    req_cnt = 0;
  int    cur_ack_n = 1;
  word_t cur_rdata = '0;
  bus_t  cur_bus;
  int    mon_stalls = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_res(input word_t wd, input logic chk_wd, input logic rfwe,
                          input reg_enum rfwa, input logic buserr, input int stalls);
    res_t r;
    r.wd = wd; r.chk_wd = chk_wd; r.rfwe = rfwe; r.rfwa = rfwa;
    r.buserr = buserr; r.stalls = stalls;
    res_q.push_back(r);
  endtask

  task automatic push_bus(input word_t addr, input logic [3:0] we, input word_t wdata,
                          input word_t wmask, input int len);
    bus_t b;
    b.addr = addr; b.we = we; b.wdata = wdata; b.wmask = wmask; b.len = len;
    bus_q.push_back(b);
  endtask

  // Memory responder and bus checker: checks the payload on the first
  // request cycle, acks on the cur_ack_n-th cycle (0 = never), checks the
  // request length when dm_req falls.
  initial begin
    cur_bus = '{addr: '0, we: '0, wdata: '0, wmask: '0, len: 0};
    forever begin
      @(negedge cpu_clk_50M);
      if (dm_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (bus_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bus_req: unexpected request addr=0x%08h, expected none", dm_addr);
            cur_bus = '{addr: '0, we: '0, wdata: '0, wmask: '0, len: 0};
          end else begin
            cur_bus = bus_q.pop_front();
            check("bus_addr", dm_addr, cur_bus.addr);
            check("bus_we", 32'(dm_we), 32'(cur_bus.we));
            check("bus_wdata", dm_wdata & cur_bus.wmask, cur_bus.wdata & cur_bus.wmask);
          end
          $display("bus: req addr=0x%08h we=%b wdata=0x%08h", dm_addr, dm_we, dm_wdata);
        end
        dm_ack   = (req_cnt == cur_ack_n);
        dm_rdata = cur_rdata;
      end else begin
        if (req_cnt != 0) check("bus_req_len", 32'(req_cnt), 32'(cur_bus.len));
        req_cnt = 0;
        dm_ack  = 1'b0;
      end
    end
  end

  // Result monitor: pops one expectation per valid result.
  initial begin
    res_t e;
    forever begin
      @(negedge cpu_clk_50M);
      if (!cpu_rst_n) begin
        mon_stalls = 0;
      end else if (mem_o_valid) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL result: unexpected valid wd=0x%08h, expected no result", mem_o_wd);
        end else begin
          e = res_q.pop_front();
          if (e.chk_wd) check("wd", mem_o_wd, e.wd);
          check("rfwe", 32'(mem_o_rfwe), 32'(e.rfwe));
          check("rfwa", 32'(mem_o_rfwa), 32'(e.rfwa));
          check("buserr", 32'(mem_o_buserr), 32'(e.buserr));
          check("stall_cycles", 32'(mon_stalls), 32'(e.stalls));
        end
        $display("result: wd=0x%08h rfwe=%0b rfwa=%0d buserr=%0b stalls=%0d",
                 mem_o_wd, mem_o_rfwe, mem_o_rfwa, mem_o_buserr, mon_stalls);
        mon_stalls = 0;
      end else if (mem_o_stall) begin
        mon_stalls++;
      end
    end
  end

  task automatic idle_inputs();
    mem_i_valid  = 1'b0;
    mem_i_memop  = '{ls_type: MEM_NONE, ls_width: LS_WORD, sign: 1'b0};
    mem_i_dm2rf  = 1'b0;
    mem_i_rfwe   = 1'b0;
    mem_i_rfwa   = REG_ZERO;
    mem_i_aluout = '0;
    mem_i_dmdin  = '0;
  endtask

  // Presents one instruction (called just after a rising edge) and holds it
  // until the stage releases the stall.
  task automatic issue(input ls_type_enum t, input ls_width_enum w, input logic sgn,
                       input logic d2rf, input logic rfwe, input reg_enum wa,
                       input word_t alu, input word_t din, input int ackn,
                       input word_t rdata);
    int guard;
    cur_ack_n    = ackn;
    cur_rdata    = rdata;
    mem_i_valid  = 1'b1;
    mem_i_memop  = '{ls_type: t, ls_width: w, sign: sgn};
    mem_i_dm2rf  = d2rf;
    mem_i_rfwe   = rfwe;
    mem_i_rfwa   = wa;
    mem_i_aluout = alu;
    mem_i_dmdin  = din;
    guard = 0;
    do begin
      @(negedge cpu_clk_50M);
      guard++;
    end while (mem_o_stall && guard < 20);
    if (mem_o_stall) begin
      n_cmp++; n_err++;
      $display("FAIL issue_stall: stall still 1 after %0d cycles, expected release", guard);
    end
    @(posedge cpu_clk_50M); #1;
    idle_inputs();
  endtask

  initial begin
    // Reset with a load presented: outputs must stay quiet.
    cpu_rst_n    = 1'b0;
    mem_i_valid  = 1'b1;
    mem_i_memop  = '{ls_type: MEM_LOAD, ls_width: LS_WORD, sign: 1'b0};
    mem_i_rfwe   = 1'b1;
    mem_i_dm2rf  = 1'b1;
    repeat (3) @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    check("rst_stall", 32'(mem_o_stall), 32'h0);
    check("rst_valid", 32'(mem_o_valid), 32'h0);
    check("rst_rfwe", 32'(mem_o_rfwe), 32'h0);
    idle_inputs();
    @(posedge cpu_clk_50M); #1;
    check("rst_dm_req", 32'(dm_req), 32'h0);
    check("rst_dm_we", 32'(dm_we), 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    check("rst_buserr", 32'(mem_o_buserr), 32'h0);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;

    // SW 0x11223344 @0x100, immediate ack
    push_bus(32'h100, 4'b1111, 32'h44332211, 32'hFFFFFFFF, 1);
    push_res(32'h0, 1'b0, 1'b0, REG_ZERO, 1'b0, 2);
    issue(MEM_STORE, LS_WORD, 1'b0, 1'b0, 1'b0, REG_ZERO, 32'h100, 32'h11223344, 1, 32'h0);

    // LB signed @0x103, ack on 3rd REQ cycle
    push_bus(32'h100, 4'b0000, 32'h0, 32'h0, 3);
    push_res(32'hFFFFFF80, 1'b1, 1'b1, REG_T0, 1'b0, 4);
    issue(MEM_LOAD, LS_BYTE, 1'b1, 1'b1, 1'b1, REG_T0, 32'h103, 32'h0, 3, 32'h80000000);

    // LBU @0x101
    push_bus(32'h100, 4'b0000, 32'h0, 32'h0, 1);
    push_res(32'h000000F0, 1'b1, 1'b1, REG_T1, 1'b0, 2);
    issue(MEM_LOAD, LS_BYTE, 1'b0, 1'b1, 1'b1, REG_T1, 32'h101, 32'h0, 1, 32'h0000F000);

    // SB 0xAB @0x102
    push_bus(32'h100, 4'b0100, 32'hABABABAB, 32'hFFFFFFFF, 1);
    push_res(32'h0, 1'b0, 1'b0, REG_ZERO, 1'b0, 2);
    issue(MEM_STORE, LS_BYTE, 1'b0, 1'b0, 1'b0, REG_ZERO, 32'h102, 32'h123456AB, 1, 32'h0);

    // LW @0x200 never acked: timeout after 4 REQ cycles
    push_bus(32'h200, 4'b0000, 32'h0, 32'h0, 4);
    push_res(32'h0, 1'b0, 1'b0, REG_T2, 1'b1, 5);
    issue(MEM_LOAD, LS_WORD, 1'b0, 1'b1, 1'b1, REG_T2, 32'h200, 32'h0, 0, 32'h0);

    // ADDU pass-through
    push_res(32'h5, 1'b1, 1'b1, REG_V0, 1'b0, 0);
    issue(MEM_NONE, LS_WORD, 1'b0, 1'b0, 1'b1, REG_V0, 32'h5, 32'h0, 0, 32'h0);

    // LH signed @0x202
    push_bus(32'h200, 4'b0000, 32'h0, 32'h0, 2);
    push_res(32'hFFFFF234, 1'b1, 1'b1, REG_T3, 1'b0, 3);
    issue(MEM_LOAD, LS_HALF, 1'b1, 1'b1, 1'b1, REG_T3, 32'h202, 32'h0, 2, 32'h34F20000);

    // LHU @0x200
    push_bus(32'h200, 4'b0000, 32'h0, 32'h0, 1);
    push_res(32'h00008134, 1'b1, 1'b1, REG_T4, 1'b0, 2);
    issue(MEM_LOAD, LS_HALF, 1'b0, 1'b1, 1'b1, REG_T4, 32'h200, 32'h0, 1, 32'h00003481);

    // SH 0x1234 @0x102 and SH 0xBEEF @0x100
    push_bus(32'h100, 4'b1100, 32'h34120000, 32'hFFFF0000, 1);
    push_res(32'h0, 1'b0, 1'b0, REG_ZERO, 1'b0, 2);
    issue(MEM_STORE, LS_HALF, 1'b0, 1'b0, 1'b0, REG_ZERO, 32'h102, 32'hFFFF1234, 1, 32'h0);
    push_bus(32'h100, 4'b0011, 32'h0000EFBE, 32'h0000FFFF, 1);
    push_res(32'h0, 1'b0, 1'b0, REG_ZERO, 1'b0, 2);
    issue(MEM_STORE, LS_HALF, 1'b0, 1'b0, 1'b0, REG_ZERO, 32'h100, 32'h0000BEEF, 1, 32'h0);

    // LW @0x104, ack on 2nd REQ cycle
    push_bus(32'h104, 4'b0000, 32'h0, 32'h0, 2);
    push_res(32'h11223344, 1'b1, 1'b1, REG_S1, 1'b0, 3);
    issue(MEM_LOAD, LS_WORD, 1'b0, 1'b1, 1'b1, REG_S1, 32'h104, 32'h0, 2, 32'h44332211);

    // LW @0x102: misaligned
`ifdef MEM_ALIGN_CHECK_EN
    push_res(32'h0, 1'b0, 1'b0, REG_T5, 1'b1, 1);
`else
    push_bus(32'h100, 4'b0000, 32'h0, 32'h0, 1);
    push_res(32'hAABBCCDD, 1'b1, 1'b1, REG_T5, 1'b0, 2);
`endif
    issue(MEM_LOAD, LS_WORD, 1'b0, 1'b1, 1'b1, REG_T5, 32'h102, 32'h0, 1, 32'hDDCCBBAA);

    // Non-memory op with rfwe=0
    push_res(32'hDEADBEEF, 1'b1, 1'b0, REG_S0, 1'b0, 0);
    issue(MEM_NONE, LS_WORD, 1'b0, 1'b0, 1'b0, REG_S0, 32'hDEADBEEF, 32'h0, 0, 32'h0);

    // Reset while in REQ: request abandoned, no result
    push_bus(32'h300, 4'b0000, 32'h0, 32'h0, 1);
    cur_ack_n    = 0;
    cur_rdata    = 32'h0;
    mem_i_valid  = 1'b1;
    mem_i_memop  = '{ls_type: MEM_LOAD, ls_width: LS_WORD, sign: 1'b0};
    mem_i_dm2rf  = 1'b1;
    mem_i_rfwe   = 1'b1;
    mem_i_rfwa   = REG_T6;
    mem_i_aluout = 32'h300;
    @(posedge cpu_clk_50M); #1;
    check("req_before_reset", 32'(dm_req), 32'h1);
    cpu_rst_n = 1'b0;
    @(negedge cpu_clk_50M);
    check("reset_in_req_stall", 32'(mem_o_stall), 32'h0);
    check("reset_in_req_valid", 32'(mem_o_valid), 32'h0);
    @(posedge cpu_clk_50M); #1;
    check("reset_in_req_dm_req", 32'(dm_req), 32'h0);
    idle_inputs();
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;

    // Back in IDLE: pass-through, then a store
    push_res(32'h77, 1'b1, 1'b1, REG_V1, 1'b0, 0);
    issue(MEM_NONE, LS_WORD, 1'b0, 1'b0, 1'b1, REG_V1, 32'h77, 32'h0, 0, 32'h0);
    push_bus(32'h0, 4'b0001, 32'h5A5A5A5A, 32'hFFFFFFFF, 1);
    push_res(32'h0, 1'b0, 1'b0, REG_ZERO, 1'b0, 2);
    issue(MEM_STORE, LS_BYTE, 1'b0, 1'b0, 1'b0, REG_ZERO, 32'h0, 32'h0000005A, 1, 32'h0);

    repeat (4) @(posedge cpu_clk_50M);
    #1;
    check("res_q_drained", 32'(res_q.size()), 32'h0);
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
